// File: rtl/regfile_write_scheduler_pkg.sv
// Shared types and sizes for the register-bank write scheduler.
//   AW/DW/NREG : index width, data width, register count
//   src_e      : write source identifier (also the round-robin pointer type)
//   wb_req_t   : one buffered writeback (destination + data)
package regfile_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 1 << AW;

    typedef enum logic {
        SRC_MEM = 1'b0,
        SRC_ALU = 1'b1
    } src_e;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_req_t;

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) c = c + {{AW{1'b0}}, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Handshake / bank-side bundle of the write scheduler.
//   master : execute/memory/decode side (drives requests, sees ready/stall/bank write)
//   slave  : the scheduler itself
interface regfile_write_scheduler_if;
    import regfile_pkg::*;

    logic          alu_valid;
    logic [AW-1:0] alu_reg;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          mem_valid;
    logic [AW-1:0] mem_reg;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          issue_valid;
    logic [AW-1:0] issue_reg;
    logic [AW-1:0] rs_a;
    logic [AW-1:0] rs_b;
    logic          stall;
    logic          wr_en;
    logic [AW-1:0] wr_reg;
    logic [DW-1:0] wr_data;
    logic [AW:0]   pending_cnt;

    modport master (
        output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
               issue_valid, issue_reg, rs_a, rs_b,
        input  alu_ready, mem_ready, stall, wr_en, wr_reg, wr_data, pending_cnt
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
               issue_valid, issue_reg, rs_a, rs_b,
        output alu_ready, mem_ready, stall, wr_en, wr_reg, wr_data, pending_cnt
    );

endinterface

// File: rtl/regfile_write_scheduler_wb_hold_buffer.sv
// One-entry holding register for a single writeback source.
//   in_valid_i/in_req_i/in_ready_o : source handshake
//   grant_i                        : arbiter drains the entry this cycle
//   hold_valid_o/hold_req_o        : current entry, seen by the arbiter
// A drained entry frees the slot in the same cycle, so a streaming source
// keeps one write per grant without a bubble.
module wb_hold_buffer
    import regfile_pkg::*;
(
    input  logic    clock,
    input  logic    reset_n,
    input  logic    in_valid_i,
    input  wb_req_t in_req_i,
    output logic    in_ready_o,
    input  logic    grant_i,
    output logic    hold_valid_o,
    output wb_req_t hold_req_o
);

    logic    valid_q, valid_d;
    wb_req_t req_q, req_d;

    assign in_ready_o   = ~valid_q | grant_i;
    assign hold_valid_o = valid_q;
    assign hold_req_o   = req_q;

    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        if (grant_i) valid_d = 1'b0;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            req_d   = in_req_i;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Write-port scheduler and hazard scoreboard for the single-write-port
// register bank.
//   clock, reset_n : rising-edge clock, async active-low reset
//   bus (slave)    : ALU/MEM write requests with ready, decode issue/sources
//                    with stall, registered bank write (wr_en/wr_reg/wr_data),
//                    and the count of reserved registers.
module regfile_write_scheduler
    import regfile_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    regfile_write_scheduler_if.slave bus
);

    wb_req_t       in_req   [2];
    wb_req_t       hold_req [2];
    logic    [1:0] in_valid, in_ready, hold_v, grant;
    src_e          rr_q, rr_d, gsrc;
    logic          any_grant, commit, reserve, stall;
    wb_req_t       greq;

    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_reg_q, wr_reg_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     pending_q, pending_d;

    assign in_valid[SRC_MEM] = bus.mem_valid;
    assign in_valid[SRC_ALU] = bus.alu_valid;
    assign in_req[SRC_MEM]   = '{rd: bus.mem_reg, data: bus.mem_data};
    assign in_req[SRC_ALU]   = '{rd: bus.alu_reg, data: bus.alu_data};

    for (genvar s = 0; s < 2; s++) begin : g_buf
        wb_hold_buffer u_buf (
            .clock       (clock),
            .reset_n     (reset_n),
            .in_valid_i  (in_valid[s]),
            .in_req_i    (in_req[s]),
            .in_ready_o  (in_ready[s]),
            .grant_i     (grant[s]),
            .hold_valid_o(hold_v[s]),
            .hold_req_o  (hold_req[s])
        );
    end

    // Round robin only matters when both entries wait; a lone entry is
    // granted regardless, and every grant hands priority to the other side.
    always_comb begin
        any_grant = |hold_v;
        gsrc      = rr_q;
        if (!(hold_v[SRC_MEM] && hold_v[SRC_ALU]))
            gsrc = hold_v[SRC_MEM] ? SRC_MEM : SRC_ALU;
        grant       = '0;
        grant[gsrc] = any_grant;
        rr_d        = any_grant ? src_e'(~gsrc) : rr_q;
    end

    assign greq   = hold_req[gsrc];
    // Reg 0 writes drain the buffer but never reach the bank.
    assign commit = any_grant && (greq.rd != '0);

    assign stall = (busy_q[bus.rs_a] && bus.rs_a != '0)
                 || (busy_q[bus.rs_b] && bus.rs_b != '0)
                 || (bus.issue_valid && bus.issue_reg != '0 && busy_q[bus.issue_reg]);
    assign reserve = bus.issue_valid && !stall && bus.issue_reg != '0;

    always_comb begin
        wr_en_d   = commit;
        wr_reg_d  = commit ? greq.rd   : wr_reg_q;
        wr_data_d = commit ? greq.data : wr_data_q;
        busy_d    = busy_q;
        if (commit)  busy_d[greq.rd]       = 1'b0;
        // Applied after the clear: a new producer outranks the retiring one.
        if (reserve) busy_d[bus.issue_reg] = 1'b1;
        pending_d = popcount(busy_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_q      <= SRC_MEM;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            rr_q      <= rr_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign bus.mem_ready   = in_ready[SRC_MEM];
    assign bus.alu_ready   = in_ready[SRC_ALU];
    assign bus.stall       = stall;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_reg      = wr_reg_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.pending_cnt = pending_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench: the stimulus task advances a queue/array reference model
// one clock at a time and pushes every bank write it predicts (with the edge
// it must appear on); the monitor pops those on each falling edge.
module tb_regfile_write_scheduler;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        time         t;
    } exp_t;

    logic clock;
    logic reset_n;
    regfile_write_scheduler_if bus();

    regfile_write_scheduler dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;

    // Reference model: index 0 = MEM, 1 = ALU.
    bit          mv [2];
    logic [4:0]  mr [2];
    logic [31:0] md [2];
    int          rr;
    bit          busy [32];
    wr_t         gen_q [2][$];
    exp_t        exp_q [$];

    // Decode-side inputs for the next step.
    bit         i_v;
    logic [4:0] i_r, ra, rb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pending();
        int c = 0;
        for (int i = 0; i < 32; i++) c += busy[i];
        return c;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            mv[s] = 0; mr[s] = '0; md[s] = '0;
            gen_q[s].delete();
        end
        for (int i = 0; i < 32; i++) busy[i] = 0;
        rr = 0;
        exp_q.delete();
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input bit dense);
        bit inv [2];
        bit rdy [2];
        bit st;
        int g;
        time t;
        for (int s = 0; s < 2; s++)
            inv[s] = (gen_q[s].size() > 0) && (dense || $urandom_range(3) != 0);
        bus.mem_valid   = inv[0];
        bus.mem_reg     = inv[0] ? gen_q[0][0].r : 5'd0;
        bus.mem_data    = inv[0] ? gen_q[0][0].d : 32'd0;
        bus.alu_valid   = inv[1];
        bus.alu_reg     = inv[1] ? gen_q[1][0].r : 5'd0;
        bus.alu_data    = inv[1] ? gen_q[1][0].d : 32'd0;
        bus.issue_valid = i_v;
        bus.issue_reg   = i_r;
        bus.rs_a        = ra;
        bus.rs_b        = rb;
        #1;
        g = -1;
        if (mv[0] && mv[1]) g = rr;
        else if (mv[0]) g = 0;
        else if (mv[1]) g = 1;
        for (int s = 0; s < 2; s++) rdy[s] = !mv[s] || (g == s);
        st = (busy[ra] && ra != 0) || (busy[rb] && rb != 0) || (i_v && i_r != 0 && busy[i_r]);
        chk("mem_ready", {31'd0, bus.mem_ready}, {31'd0, rdy[0]});
        chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, rdy[1]});
        chk("stall", {31'd0, bus.stall}, {31'd0, st});
        @(posedge clock);
        t = $time;
        if (g >= 0) begin
            if (mr[g] != 0) begin
                exp_q.push_back('{r: mr[g], d: md[g], t: t});
                busy[mr[g]] = 0;
            end
            mv[g] = 0;
            rr = 1 - g;
        end
        for (int s = 0; s < 2; s++)
            if (inv[s] && rdy[s]) begin
                mv[s] = 1;
                mr[s] = gen_q[s][0].r;
                md[s] = gen_q[s][0].d;
                void'(gen_q[s].pop_front());
            end
        if (i_v && !st && i_r != 0) busy[i_r] = 1;
        #1;
        chk("pending_cnt", {26'd0, bus.pending_cnt}, model_pending());
    endtask

    task automatic idle(input int n);
        i_v = 0; i_r = 0; ra = 0; rb = 0;
        for (int k = 0; k < n; k++) step(1);
    endtask

    // Monitor: a write predicted at rising edge t must be on the bank at t+5.
    logic [4:0]  last_r = '0;
    logic [31:0] last_d = '0;
    always @(negedge clock) begin
        if (!reset_n) begin
            last_r = '0;
            last_d = '0;
            chk("wr_en_in_reset", {31'd0, bus.wr_en}, 32'd0);
        end else if (bus.wr_en) begin
            if (exp_q.size() == 0 || exp_q[0].t + 5 != $time) begin
                chk("unexpected_wr_en", {31'd0, bus.wr_en}, 32'd0);
            end else begin
                chk("wr_reg", {27'd0, bus.wr_reg}, {27'd0, exp_q[0].r});
                chk("wr_data", bus.wr_data, exp_q[0].d);
                last_r = exp_q[0].r;
                last_d = exp_q[0].d;
                void'(exp_q.pop_front());
            end
        end else begin
            if (exp_q.size() > 0 && exp_q[0].t + 5 <= $time) begin
                chk("missing_wr_en", {31'd0, bus.wr_en}, 32'd1);
                void'(exp_q.pop_front());
            end
            chk("wr_reg_hold", {27'd0, bus.wr_reg}, {27'd0, last_r});
            chk("wr_data_hold", bus.wr_data, last_d);
        end
    end

    initial begin
        bus.alu_valid = 0; bus.alu_reg = 0; bus.alu_data = 0;
        bus.mem_valid = 0; bus.mem_reg = 0; bus.mem_data = 0;
        bus.issue_valid = 0; bus.issue_reg = 0; bus.rs_a = 0; bus.rs_b = 0;
        i_v = 0; i_r = 0; ra = 0; rb = 0;
        model_clear();
        reset_n = 0;
        #2;
        chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("rst_wr_reg", {27'd0, bus.wr_reg}, 32'd0);
        chk("rst_wr_data", bus.wr_data, 32'd0);
        chk("rst_pending", {26'd0, bus.pending_cnt}, 32'd0);
        chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        chk("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        @(posedge clock); #1;
        reset_n = 1;
        idle(2);

        // Single ALU write: one pulse two edges after the request.
        gen_q[1].push_back('{r: 5'd5, d: 32'hDEAD_BEEF});
        idle(5);

        // Both sources streaming: alternating grants, one pulse per cycle.
        for (int k = 1; k <= 4; k++) begin
            gen_q[0].push_back('{r: 5'(k), d: 32'h1000_0000 + k});
            gen_q[1].push_back('{r: 5'(k + 10), d: 32'h2000_0000 + k});
        end
        idle(12);

        // RAW: reserve 7, then hold rs_a=7 until the load for 7 commits.
        i_v = 1; i_r = 7; ra = 0; rb = 0;
        step(1);
        i_v = 0; i_r = 0; ra = 7;
        step(1); step(1);
        gen_q[0].push_back('{r: 5'd7, d: 32'h0000_0777});
        for (int k = 0; k < 5; k++) step(1);
        idle(2);

        // Reg 0: write is absorbed, issue to 0 never reserves.
        gen_q[0].push_back('{r: 5'd0, d: 32'hBAD0_0000});
        i_v = 1; i_r = 0; ra = 0; rb = 0;
        step(1); step(1); step(1);
        idle(2);

        // Collision: write to 9 commits on the edge that reserves 9.
        gen_q[1].push_back('{r: 5'd9, d: 32'h0000_0999});
        step(1);
        i_v = 1; i_r = 9;
        step(1);
        i_v = 0; i_r = 0; ra = 9;
        step(1);
        // Busy 9 with an issue to 9: the issue stalls while the write retires it.
        gen_q[0].push_back('{r: 5'd9, d: 32'h0000_9999});
        step(1);
        i_v = 1; i_r = 9; ra = 0;
        step(1); step(1); step(1);
        idle(3);

        // Reset with both buffers full and a reservation outstanding.
        i_v = 1; i_r = 20;
        step(1);
        i_v = 0; i_r = 0; ra = 20;
        for (int k = 0; k < 4; k++) begin
            gen_q[0].push_back('{r: 5'(21 + k), d: 32'h3000_0000 + k});
            gen_q[1].push_back('{r: 5'(25 + k), d: 32'h4000_0000 + k});
        end
        step(1); step(1);
        reset_n = 0;
        #1;
        chk("midrst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("midrst_pending", {26'd0, bus.pending_cnt}, 32'd0);
        chk("midrst_stall", {31'd0, bus.stall}, 32'd0);
        chk("midrst_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        chk("midrst_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        model_clear();
        bus.alu_valid = 0; bus.mem_valid = 0; bus.issue_valid = 0;
        @(posedge clock); #1;
        reset_n = 1;
        idle(3);

        // Random traffic on a narrow register range so hazards are frequent.
        for (int n = 0; n < 600; n++) begin
            for (int s = 0; s < 2; s++)
                if (gen_q[s].size() < 3 && $urandom_range(1) == 1)
                    gen_q[s].push_back('{r: 5'($urandom_range(7)), d: $urandom});
            i_v = ($urandom_range(2) == 0);
            i_r = 5'($urandom_range(7));
            ra  = 5'($urandom_range(7));
            rb  = ($urandom_range(1) == 1) ? 5'($urandom_range(31)) : 5'd0;
            step(0);
        end
        idle(8);
        chk("drain", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
